// File: rtl/gf_pkg.sv
// Package for the programmable Gaussian pulse-shaping FIR.
// Contents:
//   SYM_POS / SYM_NEG : 2-bit symbol codes for +1 / -1 (other codes mean 0)
//   DEF_COEF          : default half-response loaded into both banks on reset
//   acc_width()       : accumulator width that cannot overflow for a given length
//   def_coef()        : DEF_COEF lookup, zero beyond the end of the table
//   commit_state_e    : states of the shadow->active commit FSM
package gf_pkg;

    localparam logic [1:0] SYM_POS = 2'b01;
    localparam logic [1:0] SYM_NEG = 2'b11;

    localparam int DEF_COEF_N = 10;
    localparam int DEF_COEF [DEF_COEF_N] = '{3, 4, 6, 9, 12, 16, 19, 22, 24, 25};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } commit_state_e;

    // Every term is bounded by |h| <= 2^(CW-1) and there are ntaps of them,
    // so CW + clog2(ntaps) bits suffice; one more bit gives headroom.
    function automatic int acc_width(input int ntaps, input int cw);
        return cw + $clog2(ntaps) + 1;
    endfunction

    function automatic int def_coef(input int idx);
        if (idx >= 0 && idx < DEF_COEF_N) begin
            return DEF_COEF[idx];
        end
        return 0;
    endfunction

endpackage

// File: rtl/gf_tap_sel.sv
// Sign-select of one coefficient by one ternary symbol.
// Ports:
//   sym_i  : symbol code (SYM_POS = +1, SYM_NEG = -1, anything else = 0)
//   coef_i : signed coefficient, CW bits
//   term_o : +coef / -coef / 0, sign-extended to the accumulator width ACCW
module gf_tap_sel
    import gf_pkg::*;
#(
    parameter int CW   = 9,
    parameter int ACCW = 15
) (
    input  logic        [1:0]      sym_i,
    input  logic signed [CW-1:0]   coef_i,
    output logic signed [ACCW-1:0] term_o
);

    logic signed [ACCW-1:0] coef_ext;

    // Extend before negating so the most negative coefficient negates cleanly.
    assign coef_ext = ACCW'(coef_i);

    always_comb begin
        term_o = '0;
        case (sym_i)
            SYM_POS: term_o = coef_ext;
            SYM_NEG: term_o = -coef_ext;
            default: term_o = '0;
        endcase
    end

endmodule

// File: rtl/gf_prog_fir.sv
// Programmable symmetric Gaussian pulse-shaping FIR for the GFSK baseband path.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clk_en        : sample-rate enable; nothing advances when low
//   x, x_valid    : ternary symbol and its qualifier (accepted when clk_en & x_valid)
//   y, y_valid    : registered saturated shaped sample, one-cycle update pulse
//   coef_we, coef_addr, coef_wdata : shadow-bank write port (HALF unique taps)
//   coef_commit   : request a shadow->active bank copy
//   coef_busy     : commit pending; shadow writes and further commits ignored
// The active bank is only replaced on an enabled edge, and the output computed
// on that same edge is taken from the old bank, so no sample mixes two banks.
module gf_prog_fir
    import gf_pkg::*;
#(
    parameter  int NTAPS = 19,
    parameter  int CW    = 9,
    parameter  int OW    = 12,
    localparam int HALF  = (NTAPS + 1) / 2,
    localparam int AW    = (HALF > 1) ? $clog2(HALF) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic        [1:0]    x,
    input  logic                 x_valid,
    output logic signed [OW-1:0] y,
    output logic                 y_valid,
    input  logic                 coef_we,
    input  logic        [AW-1:0] coef_addr,
    input  logic signed [CW-1:0] coef_wdata,
    input  logic                 coef_commit,
    output logic                 coef_busy
);

    localparam int ACCW   = acc_width(NTAPS, CW);
    // Compare in a width that holds both the accumulator and the OW limits.
    localparam int CMPW   = (ACCW > OW + 1) ? ACCW : OW + 1;
    localparam int OMAX_I = (1 <<< (OW - 1)) - 1;
    localparam logic signed [CMPW-1:0] OMAX = CMPW'(OMAX_I);
    localparam logic signed [CMPW-1:0] OMIN = CMPW'(-OMAX_I - 1);
    localparam logic signed [OW-1:0]   YMAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0]   YMIN = {1'b1, {(OW-1){1'b0}}};

    logic        [1:0]      d_q      [NTAPS];
    logic        [1:0]      d_shift  [NTAPS];
    logic signed [CW-1:0]   active_q [HALF];
    logic signed [CW-1:0]   shadow_q [HALF];
    logic signed [ACCW-1:0] term     [NTAPS];

    logic signed [ACCW-1:0] acc;
    logic signed [CMPW-1:0] acc_ext;
    logic signed [OW-1:0]   y_sat;
    logic signed [OW-1:0]   y_q;
    logic                   y_valid_q;
    logic                   accept;

    commit_state_e state_q;
    commit_state_e state_d;
    logic          shadow_we;
    logic          bank_copy;

    assign accept = clk_en & x_valid;

    // ---------------------------------------------------------------
    // Delay line and per-tap sign selection. The sum is formed from the
    // post-shift line so the output appears one clock after its accept.
    // ---------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NTAPS; gi++) begin : g_tap
            // Folded index: taps k and NTAPS-1-k share one stored coefficient.
            localparam int HI = (gi < NTAPS - 1 - gi) ? gi : NTAPS - 1 - gi;

            if (gi == 0) begin : g_head
                assign d_shift[gi] = x;
            end else begin : g_body
                assign d_shift[gi] = d_q[gi-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    d_q[gi] <= 2'b00;
                end else if (accept) begin
                    d_q[gi] <= d_shift[gi];
                end
            end

            gf_tap_sel #(
                .CW   (CW),
                .ACCW (ACCW)
            ) u_tap_sel (
                .sym_i  (d_shift[gi]),
                .coef_i (active_q[HI]),
                .term_o (term[gi])
            );
        end
    endgenerate

    always_comb begin
        acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            acc = acc + term[k];
        end
    end

    assign acc_ext = CMPW'(acc);

    always_comb begin
        y_sat = OW'(acc_ext);
        if (acc_ext > OMAX) begin
            y_sat = YMAX;
        end else if (acc_ext < OMIN) begin
            y_sat = YMIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= accept;
            if (accept) begin
                y_q <= y_sat;
            end
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;

    // ---------------------------------------------------------------
    // Coefficient banks. Each entry has its own write decode, which also
    // drops out-of-range addresses without an explicit bound check.
    // ---------------------------------------------------------------
    generate
        for (gi = 0; gi < HALF; gi++) begin : g_bank
            always_ff @(posedge clk) begin
                if (rst) begin
                    active_q[gi] <= CW'(def_coef(gi));
                    shadow_q[gi] <= CW'(def_coef(gi));
                end else begin
                    if (shadow_we && (int'(coef_addr) == gi)) begin
                        shadow_q[gi] <= coef_wdata;
                    end
                    if (bank_copy) begin
                        active_q[gi] <= shadow_q[gi];
                    end
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------------
    // Commit FSM: state register / next state / outputs.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (coef_commit) state_d = ST_ARMED;
            ST_ARMED: if (clk_en)      state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        coef_busy = (state_q == ST_ARMED);
        // A write in the same cycle as the commit request still lands.
        shadow_we = (state_q == ST_IDLE) && coef_we;
        bank_copy = (state_q == ST_ARMED) && clk_en;
    end

endmodule

// File: tb/tb_gf_prog_fir.sv
// Directed self-checking bench for gf_prog_fir at default parameters.
module tb_gf_prog_fir;

    import gf_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               clk_en;
    logic        [1:0]  x;
    logic               x_valid;
    logic signed [11:0] y;
    logic               y_valid;
    logic               coef_we;
    logic        [3:0]  coef_addr;
    logic signed [8:0]  coef_wdata;
    logic               coef_commit;
    logic               coef_busy;

    int checks = 0;
    int errors = 0;

    int imp [19] = '{3, 4, 6, 9, 12, 16, 19, 22, 24, 25, 24, 22, 19, 16, 12, 9, 6, 4, 3};

    gf_prog_fir #(
        .NTAPS (19),
        .CW    (9),
        .OW    (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .x           (x),
        .x_valid     (x_valid),
        .y           (y),
        .y_valid     (y_valid),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_wdata  (coef_wdata),
        .coef_commit (coef_commit),
        .coef_busy   (coef_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for the active edge, then move 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc_sym(input logic [1:0] s);
        x       = s;
        x_valid = 1'b1;
        clk_en  = 1'b1;
        tick();
        x_valid = 1'b0;
        x       = 2'b00;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) acc_sym(2'b00);
    endtask

    task automatic wr_coef(input logic [3:0] a, input logic signed [8:0] v);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = v;
        tick();
        coef_we    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; x = 2'b00; x_valid = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; coef_commit = 1'b0;
        tick();
        tick();
        check("reset_y", $signed(y), 0);
        check("reset_y_valid", {31'd0, y_valid}, 0);
        check("reset_busy", {31'd0, coef_busy}, 0);
        rst = 1'b0;
        tick();
        check("idle_y_valid", {31'd0, y_valid}, 0);

        // 1: impulse response with the default bank
        for (int i = 0; i < 19; i++) begin
            acc_sym((i == 0) ? SYM_POS : 2'b00);
            check($sformatf("impulse_y[%0d]", i), $signed(y), imp[i]);
            check($sformatf("impulse_vld[%0d]", i), {31'd0, y_valid}, 1);
        end
        acc_sym(2'b00);
        check("impulse_tail", $signed(y), 0);

        // 5: enable/valid hold in the middle of an impulse
        acc_sym(SYM_POS);
        flush(4);
        check("hold_pre", $signed(y), 12);
        x = SYM_POS; x_valid = 1'b1; clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold_en_y[%0d]", i), $signed(y), 12);
            check($sformatf("hold_en_vld[%0d]", i), {31'd0, y_valid}, 0);
        end
        x = 2'b00; x_valid = 1'b0; clk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_vgap_y[%0d]", i), $signed(y), 12);
            check($sformatf("hold_vgap_vld[%0d]", i), {31'd0, y_valid}, 0);
        end
        acc_sym(2'b00);
        check("hold_resume", $signed(y), 16);
        flush(19);
        check("hold_flushed", $signed(y), 0);

        // 2: steady state, mixed line, code 2'b10
        acc_sym(SYM_POS);
        check("steady_pos_first", $signed(y), 3);
        for (int i = 0; i < 29; i++) acc_sym(SYM_POS);
        check("steady_pos", $signed(y), 255);
        for (int i = 0; i < 10; i++) acc_sym(SYM_NEG);
        check("mixed_10neg", $signed(y), -25);
        for (int i = 0; i < 20; i++) acc_sym(SYM_NEG);
        check("steady_neg", $signed(y), -255);
        acc_sym(2'b10);
        check("code_10_zero", $signed(y), -252);
        flush(19);
        check("steady_flushed", $signed(y), 0);

        // 4: commit timing
        acc_sym(SYM_POS);
        flush(8);
        check("commit_pre", $signed(y), 24);
        clk_en = 1'b0;
        coef_we = 1'b1; coef_addr = 4'd9; coef_wdata = 9'sd100; coef_commit = 1'b1;
        tick();
        coef_we = 1'b0; coef_commit = 1'b0;
        check("commit_busy", {31'd0, coef_busy}, 1);
        check("commit_y_hold", $signed(y), 24);
        check("commit_y_valid", {31'd0, y_valid}, 0);
        wr_coef(4'd9, 9'sd7);
        check("commit_busy_hold", {31'd0, coef_busy}, 1);
        acc_sym(2'b00);
        check("commit_edge_old_bank", $signed(y), 25);
        check("commit_done", {31'd0, coef_busy}, 0);
        acc_sym(2'b00);
        check("commit_after", $signed(y), 24);
        flush(19);
        acc_sym(SYM_POS);
        flush(8);
        check("new_bank_tap8", $signed(y), 24);
        acc_sym(2'b00);
        check("new_bank_centre", $signed(y), 100);
        acc_sym(2'b00);
        check("new_bank_tap10", $signed(y), 24);
        flush(19);

        // 3: saturation with every coefficient at 255
        clk_en = 1'b0;
        for (int i = 0; i < 10; i++) wr_coef(4'(i), 9'sd255);
        wr_coef(4'd12, -9'sd1);
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        check("sat_busy", {31'd0, coef_busy}, 1);
        clk_en = 1'b1;
        tick();
        check("sat_committed", {31'd0, coef_busy}, 0);
        acc_sym(SYM_POS);
        check("sat_pos_1", $signed(y), 255);
        for (int i = 0; i < 7; i++) acc_sym(SYM_POS);
        check("sat_pos_8", $signed(y), 2040);
        acc_sym(SYM_POS);
        check("sat_pos_9", $signed(y), 2047);
        for (int i = 0; i < 21; i++) acc_sym(SYM_POS);
        check("sat_pos_steady", $signed(y), 2047);
        for (int i = 0; i < 10; i++) acc_sym(SYM_NEG);
        check("sat_mixed_10neg", $signed(y), -255);
        for (int i = 0; i < 20; i++) acc_sym(SYM_NEG);
        check("sat_neg_steady", $signed(y), -2048);

        // 6: reset mid-stream with a commit pending
        acc_sym(SYM_POS);
        flush(3);
        clk_en = 1'b0; coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        check("rst_pre_busy", {31'd0, coef_busy}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_y", $signed(y), 0);
        check("rst_mid_y_valid", {31'd0, y_valid}, 0);
        check("rst_mid_busy", {31'd0, coef_busy}, 0);
        for (int i = 0; i < 19; i++) begin
            acc_sym((i == 0) ? SYM_POS : 2'b00);
            check($sformatf("rst_impulse_y[%0d]", i), $signed(y), imp[i]);
        end
        check("rst_busy_final", {31'd0, coef_busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
